// File: rtl/fir_mac_filter_if.sv
// Sample/coefficient/result bundle for fir_mac_filter.
// The master side feeds samples and coefficients; the slave side is the filter.
interface fir_mac_filter_if #(
   parameter int DATA_W = 20,
   parameter int COEF_W = 16,
   parameter int TAPS   = 16
);
   localparam int AW = $clog2(TAPS);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              coef_we;
   logic [AW-1:0]     coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, coef_we, coef_addr, coef_data,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, coef_we, coef_addr, coef_data,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR: one signed multiplier and one accumulator, TAPS cycles per sample.
// Define FIR_SATURATE_EN to clamp the output; without it the output wraps.
module fir_mac_filter #(
   parameter int DATA_W = 20,
   parameter int COEF_W = 16,
   parameter int TAPS   = 16
) (
   input logic            clk,
   input logic            rst_n,
   fir_mac_filter_if.slave bus
);
   localparam int AW     = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + AW;

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

   state_t                      state_q, state_d;
   logic [TAPS-1:0][DATA_W-1:0] dly_q;
   logic [TAPS-1:0][COEF_W-1:0] coef_q;
   logic signed [ACC_W-1:0]     acc_q;
   logic [AW-1:0]               idx_q;
   logic [DATA_W-1:0]           out_q;
   logic                        vld_q;

   logic                        accept, last_tap, coef_ok;
   logic signed [PROD_W-1:0]    x_ext, h_ext, prod;
   logic [DATA_W-1:0]           res;

   assign accept   = (state_q == IDLE) && bus.in_valid;
   assign last_tap = (idx_q == AW'(TAPS - 1));
   assign coef_ok  = (state_q == IDLE) && bus.coef_we && (32'(bus.coef_addr) < TAPS);

   assign x_ext = {{COEF_W{dly_q[idx_q][DATA_W-1]}}, dly_q[idx_q]};
   assign h_ext = {{DATA_W{coef_q[idx_q][COEF_W-1]}}, coef_q[idx_q]};
   assign prod  = x_ext * h_ext;

`ifdef FIR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({(DATA_W-1){1'b1}});
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   logic signed [ACC_W-1:0] shifted;

   assign shifted = acc_q >>> (COEF_W - 1);

   always_comb begin
      res = shifted[DATA_W-1:0];
      if (shifted > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (shifted < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
   end
`else
   // Q1.(COEF_W-1) rescale then keep the low DATA_W bits.
   assign res = acc_q[COEF_W-1 +: DATA_W];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.in_valid) state_d = MAC;
         MAC:     if (last_tap)     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dly_q  <= '0;
         coef_q <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
         out_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= (state_q == DONE);
         // Write lands on the accepting edge, so the pass that follows sees it.
         if (coef_ok) coef_q[bus.coef_addr] <= bus.coef_data;
         if (accept) begin
            dly_q <= {dly_q[TAPS-2:0], bus.in_data};
            acc_q <= '0;
            idx_q <= '0;
         end else if (state_q == MAC) begin
            acc_q <= acc_q + {{AW{prod[PROD_W-1]}}, prod};
            if (!last_tap) idx_q <= idx_q + AW'(1);
         end
         if (state_q == DONE) out_q <= res;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = vld_q;
   assign bus.out_data  = out_q;
endmodule

// File: tb/tb_fir_mac_filter.sv
// Scoreboard bench for fir_mac_filter: directed samples push hand-computed results,
// a negedge monitor pops and compares data and latency on every out_valid.
module tb_fir_mac_filter;
   localparam int DATA_W = 20;
   localparam int COEF_W = 16;
   localparam int TAPS   = 16;
   localparam int LAT    = (TAPS + 1) * 10 + 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fir_mac_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus();

   fir_mac_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      time               t_acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_out = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         n_out++;
         if (sb_q.size() == 0) check("unexpected_out_valid", 1, 0);
         else begin
            e = sb_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("latency", $time - e.t_acc, LAT);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic wcoef(input int addr, input int val);
      bus.coef_we   = 1'b1;
      bus.coef_addr = addr[3:0];
      bus.coef_data = val[COEF_W-1:0];
      tick();
      bus.coef_we   = 1'b0;
   endtask

   task automatic send(input int x, input longint ex, input bit push, input bit hold = 1'b0);
      int g = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = x[DATA_W-1:0];
      while (bus.in_ready !== 1'b1 && g < 100) begin
         tick();
         g++;
      end
      if (bus.in_ready !== 1'b1) begin
         check("in_ready_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (push) sb_q.push_back('{data: ex[DATA_W-1:0], t_acc: $time});
      #1;
      check("in_ready_low_in_pass", bus.in_ready, 0);
      if (!hold) bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb_q.size() != 0 && g < 200) begin
         tick();
         g++;
      end
      check("drain", sb_q.size(), 0);
      tick(2);
   endtask

   function automatic longint sat_exp(input int k);
      longint s;
      s = (longint'(k) * 524287 * 32767) >>> 15;
`ifdef FIR_SATURATE_EN
      if (s > 524287) s = 524287;
`endif
      return s & 64'hFFFFF;
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #2;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      tick(2);
      rst_n = 1'b1;
      tick();

      // impulse, then out_data must hold
      wcoef(0, 16384);
      send(1000, 500, 1);
      drain();
      tick(5);
      check("out_hold", bus.out_data, 500);

      // delay line through tap 3
      do_reset();
      wcoef(3, 32767);
      send(1000, 0, 1);
      send(0, 0, 1);
      send(0, 0, 1);
      send(0, 999, 1);
      drain();

      // back-pressure: in_valid held across five samples
      do_reset();
      wcoef(0, 16384);
      for (int i = 1; i <= 5; i++) send(2 * i, i, 1, i != 5);
      drain();
      check("bp_out_count", n_out, 10);

      // full-scale accumulation
      do_reset();
      for (int a = 0; a < TAPS; a++) wcoef(a, 32767);
      for (int k = 1; k < 16; k++) send(524287, sat_exp(k), 1);
`ifdef FIR_SATURATE_EN
      send(524287, 524287, 1);
`else
      send(524287, 1048304, 1);
`endif
      drain();

      // coefficient gating
      do_reset();
      wcoef(0, 16384);
      send(1000, 500, 1);
      tick(3);
      bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 16'd32767;
      tick();
      bus.coef_we = 1'b0;
      drain();
      send(2000, 1000, 1);
      drain();
      bus.coef_we = 1'b1; bus.coef_addr = '0; bus.coef_data = 16'd32767;
      send(3000, 2999, 1);
      bus.coef_we = 1'b0;
      drain();

      // reset in the middle of a pass
      do_reset();
      wcoef(0, 16384);
      send(1000, 0, 0);
      tick(7);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_out_data", bus.out_data, 0);
      tick();
      rst_n = 1'b1;
      tick(TAPS + 5);
      send(1000, 0, 1);
      drain();

      check("total_out_count", n_out, 30);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
